// File: rtl/regfile_copy_engine.sv
// regfile_copy_engine: register-file initiator that executes one COPY or FILL
// command at a time over a read/write regfile port pair.
// COPY moves LEN words from SRC to DST in ascending order, reading each word
// only after the previous one has been written. FILL writes CMD_DATA to LEN
// words starting at DST. Indices wrap modulo 2**n, and LEN is clamped to 2**n.
// Optional feature macro: REGFILE_COPY_CHECKSUM_EN adds the CHECKSUM output,
// which is the XOR of every word written by the current command.
//
// Handshake: a command is accepted on a rising CLK edge where CMD_VALID and
// CMD_READY are both 1. CMD_READY is 1 only in IDLE. CMD_VALID offered while
// CMD_READY is 0 is dropped and never queued. The read port is a request/
// response pair: READ_REQ_WRITE_VALID and READ_REQ_WRITE stay stable until an
// edge where READ_RESP_READ_VALID is 1. That edge consumes the response.
module regfile_copy_engine #(
  parameter int width = 32,
  parameter int n     = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_OP,
  input  logic [n-1:0]     CMD_SRC,
  input  logic [n-1:0]     CMD_DST,
  input  logic [n:0]       CMD_LEN,
  input  logic [width-1:0] CMD_DATA,
  output logic [n-1:0]     READ_REQ_WRITE,
  output logic             READ_REQ_WRITE_VALID,
  input  logic [width-1:0] READ_RESP_READ,
  input  logic             READ_RESP_READ_VALID,
  output logic             WRITE_EN_WRITE,
  output logic [n-1:0]     WRITE_INDEX_WRITE,
  output logic [width-1:0] WRITE_DATA_WRITE,
  output logic             BUSY,
  output logic             DONE_PULSE,
`ifdef REGFILE_COPY_CHECKSUM_EN
  output logic [width-1:0] CHECKSUM,
`endif
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [n:0]   LEN_MAX = {1'b1, {n{1'b0}}};
  localparam logic [n-1:0] ONE_N   = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n:0]   ONE_L   = {{n{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [n-1:0]     src_ptr, dst_ptr;
  logic [n:0]       remaining;
  logic             op_q;
  logic [width-1:0] fill_q;
  logic [width-1:0] hold_q;
  logic             cmd_fire;
  logic [n:0]       len_clamp;

  assign cmd_fire  = (state == IDLE) && CMD_VALID;
  assign len_clamp = (CMD_LEN > LEN_MAX) ? LEN_MAX : CMD_LEN;
  assign BUSY      = (state != IDLE);
  assign DBG_STATE = state;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and port decode. Ports are forced to 0 outside their active state.
  always_comb begin
    state_nxt            = state;
    CMD_READY            = 1'b0;
    READ_REQ_WRITE_VALID = 1'b0;
    READ_REQ_WRITE       = '0;
    WRITE_EN_WRITE       = 1'b0;
    WRITE_INDEX_WRITE    = '0;
    WRITE_DATA_WRITE     = '0;
    DONE_PULSE           = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          if (len_clamp == '0) begin
            state_nxt = FIN;
          end else if (CMD_OP) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        READ_REQ_WRITE_VALID = 1'b1;
        READ_REQ_WRITE       = src_ptr;
        if (READ_RESP_READ_VALID) begin
          state_nxt = WR;
        end
      end
      WR: begin
        WRITE_EN_WRITE    = 1'b1;
        WRITE_INDEX_WRITE = dst_ptr;
        WRITE_DATA_WRITE  = op_q ? fill_q : hold_q;
        if (remaining == ONE_L) begin
          state_nxt = FIN;
        end else if (!op_q) begin
          state_nxt = RD;
        end
      end
      FIN: begin
        DONE_PULSE = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command registers, pointers and the read-data hold register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      op_q      <= 1'b0;
      fill_q    <= '0;
      hold_q    <= '0;
    end else begin
      if (cmd_fire) begin
        src_ptr   <= CMD_SRC;
        dst_ptr   <= CMD_DST;
        remaining <= len_clamp;
        op_q      <= CMD_OP;
        fill_q    <= CMD_DATA;
      end
      if ((state == RD) && READ_RESP_READ_VALID) begin
        hold_q <= READ_RESP_READ;
      end
      if (state == WR) begin
        src_ptr   <= src_ptr + ONE_N;
        dst_ptr   <= dst_ptr + ONE_N;
        remaining <= remaining - ONE_L;
      end
    end
  end

`ifdef REGFILE_COPY_CHECKSUM_EN
  // Running XOR of written words. It is cleared when a command is accepted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CHECKSUM <= '0;
    end else if (cmd_fire) begin
      CHECKSUM <= '0;
    end else if (state == WR) begin
      CHECKSUM <= CHECKSUM ^ WRITE_DATA_WRITE;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_copy_engine.sv
// tb_regfile_copy_engine: drives regfile_copy_engine against a behavioural
// regfile responder with programmable read latency. Each command is checked
// against a word-level reference model: an array plus an expected-write queue.
module tb_regfile_copy_engine;

  localparam int WIDTH = 32;
  localparam int N     = 5;
  localparam int DEPTH = 32;
  localparam int EW    = N + WIDTH;

  logic             CLK;
  logic             RESET;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic             CMD_OP;
  logic [N-1:0]     CMD_SRC;
  logic [N-1:0]     CMD_DST;
  logic [N:0]       CMD_LEN;
  logic [WIDTH-1:0] CMD_DATA;
  logic [N-1:0]     READ_REQ_WRITE;
  logic             READ_REQ_WRITE_VALID;
  logic [WIDTH-1:0] READ_RESP_READ;
  logic             READ_RESP_READ_VALID;
  logic             WRITE_EN_WRITE;
  logic [N-1:0]     WRITE_INDEX_WRITE;
  logic [WIDTH-1:0] WRITE_DATA_WRITE;
  logic             BUSY;
  logic             DONE_PULSE;
  logic [1:0]       dbg_state;
`ifdef REGFILE_COPY_CHECKSUM_EN
  logic [WIDTH-1:0] CHECKSUM;
`endif

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] gold    [DEPTH];
  logic [WIDTH-1:0] pre_arr [DEPTH];
  logic             preload_req;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_e;
  logic [N-1:0]     last_ridx;
  logic [WIDTH-1:0] exp_sum;
  int               err_cnt;
  int               chk_cnt;
  int               wait_cfg;
  int               wait_cnt;
  int               wr_cnt;

  regfile_copy_engine #(.width(WIDTH), .n(N)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .CMD_VALID            (CMD_VALID),
    .CMD_READY            (CMD_READY),
    .CMD_OP               (CMD_OP),
    .CMD_SRC              (CMD_SRC),
    .CMD_DST              (CMD_DST),
    .CMD_LEN              (CMD_LEN),
    .CMD_DATA             (CMD_DATA),
    .READ_REQ_WRITE       (READ_REQ_WRITE),
    .READ_REQ_WRITE_VALID (READ_REQ_WRITE_VALID),
    .READ_RESP_READ       (READ_RESP_READ),
    .READ_RESP_READ_VALID (READ_RESP_READ_VALID),
    .WRITE_EN_WRITE       (WRITE_EN_WRITE),
    .WRITE_INDEX_WRITE    (WRITE_INDEX_WRITE),
    .WRITE_DATA_WRITE     (WRITE_DATA_WRITE),
    .BUSY                 (BUSY),
    .DONE_PULSE           (DONE_PULSE),
`ifdef REGFILE_COPY_CHECKSUM_EN
    .CHECKSUM             (CHECKSUM),
`endif
    .DBG_STATE            (dbg_state)
  );

  // Clock and reset.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder: the response is valid once the request has waited wait_cfg cycles.
  assign READ_RESP_READ_VALID = READ_REQ_WRITE_VALID && (wait_cnt >= wait_cfg);
  assign READ_RESP_READ       = READ_RESP_READ_VALID ? mem[READ_REQ_WRITE] : '0;

  always @(posedge CLK) begin
    if (preload_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_arr[i];
    end else if (WRITE_EN_WRITE) begin
      mem[WRITE_INDEX_WRITE] <= WRITE_DATA_WRITE;
    end
    if (READ_REQ_WRITE_VALID && !READ_RESP_READ_VALID) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Scoreboard: compares every write strobe with the head of exp_q and checks that a waiting read index stays stable.
  always @(negedge CLK) begin
    if (WRITE_EN_WRITE) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 64'(WRITE_INDEX_WRITE), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("write", 64'({WRITE_INDEX_WRITE, WRITE_DATA_WRITE}), 64'(mon_e));
      end
    end
    if (READ_REQ_WRITE_VALID && wait_cnt > 0) check_eq("rd_idx_hold", 64'(READ_REQ_WRITE), 64'(last_ridx));
    last_ridx = READ_REQ_WRITE;
  end

  task automatic preload(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      pre_arr[i] = (mode == 0) ? WIDTH'(i) : $urandom;
      gold[i]    = pre_arr[i];
    end
    @(negedge CLK);
    preload_req = 1'b1;
    @(negedge CLK);
    preload_req = 1'b0;
  endtask

  // Reference model: words are processed in ascending order, and each source is read after the earlier writes.
  task automatic build_exp(input logic op, input int src, input int dst, input int eff,
                           input logic [WIDTH-1:0] data, input int limit);
    logic [WIDTH-1:0] d;
    int di;
    exp_sum = '0;
    for (int i = 0; i < eff && i < limit; i++) begin
      di = (dst + i) % DEPTH;
      d  = op ? data : gold[(src + i) % DEPTH];
      gold[di] = d;
      exp_sum  = exp_sum ^ d;
      exp_q.push_back({N'(di), d});
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) bad++;
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  task automatic drive_cmd(input logic op, input int src, input int dst, input int len,
                           input logic [WIDTH-1:0] data);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_SRC   = N'(src);
    CMD_DST   = N'(dst);
    CMD_LEN   = (N+1)'(len);
    CMD_DATA  = data;
  endtask

  // Driver: issues one command and checks latency, DONE_PULSE, idle state, queue drain and final memory image.
  task automatic run_cmd(input logic op, input int src, input int dst, input int len,
                         input logic [WIDTH-1:0] data, input int w, input bit poke);
    int eff, cyc, exp_lat;
    eff      = (len > DEPTH) ? DEPTH : len;
    wait_cfg = w;
    build_exp(op, src, dst, eff, data, DEPTH + 1);
    exp_lat  = (eff == 0) ? 1 : (op ? eff + 1 : eff * (w + 2) + 1);
    @(negedge CLK);
    cyc = 0;
    while (!CMD_READY && cyc < 300) begin @(negedge CLK); cyc++; end
    check_eq("ready_before_cmd", 64'(CMD_READY), 64'd1);
    drive_cmd(op, src, dst, len, data);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (poke && cyc == 1) drive_cmd(1'b1, 0, 0, 5, 32'hDEAD_BEEF);
      if (poke && cyc == 2) CMD_VALID = 1'b0;
    end while (!DONE_PULSE && cyc < 2000);
    CMD_VALID = 1'b0;
    check_eq("done_latency", 64'(cyc), 64'(exp_lat));
    check_eq("busy_at_done", 64'(BUSY), 64'd1);
    check_eq("ready_at_done", 64'(CMD_READY), 64'd0);
`ifdef REGFILE_COPY_CHECKSUM_EN
    check_eq("checksum", 64'(CHECKSUM), 64'(exp_sum));
`endif
    @(negedge CLK);
    check_eq("done_one_cycle", 64'(DONE_PULSE), 64'd0);
    check_eq("idle_ready", 64'(CMD_READY), 64'd1);
    check_eq("idle_busy", 64'(BUSY), 64'd0);
    if (poke) repeat (6) @(negedge CLK);
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check_mem("mem_image");
  endtask

  initial begin
    int base, cyc;
    err_cnt = 0; chk_cnt = 0; wait_cfg = 0;
    preload_req = 1'b0;
    CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_SRC = '0; CMD_DST = '0; CMD_LEN = '0; CMD_DATA = '0;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    // Reset values
    check_eq("rst_ready", 64'(CMD_READY), 64'd1);
    check_eq("rst_busy", 64'(BUSY), 64'd0);
    check_eq("rst_done", 64'(DONE_PULSE), 64'd0);
    check_eq("rst_rvalid", 64'(READ_REQ_WRITE_VALID), 64'd0);
    check_eq("rst_wen", 64'(WRITE_EN_WRITE), 64'd0);
    check_eq("rst_outs", 64'({READ_REQ_WRITE, WRITE_INDEX_WRITE, WRITE_DATA_WRITE}), 64'd0);
    RESET = 1'b0;
    preload(0);

    // Directed cases
    run_cmd(1'b1, 0, 3, 4, 32'hA5A5_A5A5, 0, 1'b0);
    check_eq("fill_idx6", 64'(mem[6]), 64'hA5A5_A5A5);
    check_eq("fill_idx7_untouched", 64'(mem[7]), 64'd7);
    preload(0);
    run_cmd(1'b0, 0, 16, 8, '0, 0, 1'b0);
    check_eq("copy_23", 64'(mem[23]), 64'd7);
    run_cmd(1'b0, 30, 0, 4, '0, 0, 1'b0);
    check_eq("wrap_0", 64'(mem[0]), 64'd30);
    check_eq("wrap_1", 64'(mem[1]), 64'd31);
    check_eq("wrap_2", 64'(mem[2]), 64'd30);
    check_eq("wrap_3", 64'(mem[3]), 64'd31);
    run_cmd(1'b0, 5, 9, 0, '0, 0, 1'b0);
    run_cmd(1'b1, 7, 7, 32, 32'h1234_5678, 0, 1'b0);
    run_cmd(1'b1, 2, 11, 40, 32'h0BAD_F00D, 0, 1'b0);
    run_cmd(1'b1, 0, 4, 6, 32'h5555_0000, 0, 1'b1);
    preload(1);
    run_cmd(1'b0, 10, 11, 5, '0, 0, 1'b0);
    run_cmd(1'b0, 2, 20, 4, '0, 3, 1'b0);

`ifdef REGFILE_COPY_CHECKSUM_EN
    run_cmd(1'b1, 0, 12, 3, 32'h1, 0, 1'b0);
    check_eq("cks_fill", 64'(CHECKSUM), 64'h1);
    for (int i = 0; i < DEPTH; i++) begin pre_arr[i] = 32'h0; gold[i] = 32'h0; end
    pre_arr[8] = 32'h1; pre_arr[9] = 32'h2; pre_arr[10] = 32'h4;
    gold[8] = 32'h1; gold[9] = 32'h2; gold[10] = 32'h4;
    @(negedge CLK); preload_req = 1'b1; @(negedge CLK); preload_req = 1'b0;
    run_cmd(1'b0, 8, 24, 3, '0, 1, 1'b0);
    check_eq("cks_copy", 64'(CHECKSUM), 64'h7);
`endif

    // Reset during a slow COPY: only the first two writes may land.
    preload(1);
    wait_cfg = 3;
    build_exp(1'b0, 4, 20, 4, '0, 2);
    @(negedge CLK);
    drive_cmd(1'b0, 4, 20, 4, '0);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    base = wr_cnt;
    cyc = 0;
    while (wr_cnt < base + 2 && cyc < 200) begin @(negedge CLK); cyc++; end
    check_eq("rst_mid_two_writes", 64'(wr_cnt - base), 64'd2);
    @(posedge CLK);
    #1 RESET = 1'b1;
    #1;
    check_eq("rst_mid_wen", 64'(WRITE_EN_WRITE), 64'd0);
    check_eq("rst_mid_rvalid", 64'(READ_REQ_WRITE_VALID), 64'd0);
    check_eq("rst_mid_busy", 64'(BUSY), 64'd0);
    check_eq("rst_mid_ready", 64'(CMD_READY), 64'd1);
    check_eq("rst_mid_outs", 64'({READ_REQ_WRITE, WRITE_INDEX_WRITE, WRITE_DATA_WRITE}), 64'd0);
`ifdef REGFILE_COPY_CHECKSUM_EN
    check_eq("rst_mid_cks", 64'(CHECKSUM), 64'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    check_eq("rst_mid_q", 64'(exp_q.size()), 64'd0);
    check_mem("rst_mid_mem");

    // Randomized commands
    for (int t = 0; t < 30; t++) begin
      if (t % 6 == 0) preload(1);
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 40), $urandom, $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
